// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store.
// Optional fetch anti-starvation counter is enabled with `define MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  state_t      state, state_nxt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_we;
  logic        r_err;

  logic [1:0]  off;
  logic        misaligned;
  logic        fetch_first;
  logic [3:0]  lane_we;
  logic [31:0] repl;

  assign off        = d_addr[1:0];
  // Size 11 behaves as a word, so d_size[1] alone marks word accesses.
  assign misaligned = ((d_size == 2'b01) && off[0]) || (d_size[1] && (off != 2'b00));

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (if_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign fetch_first = if_req && (starve_cnt == 4'(STARVE_MAX));
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (fetch_first)  if_gnt = 1'b1;
      else if (d_req)   d_gnt  = 1'b1;
      else if (if_req)  if_gnt = 1'b1;
    end
  end

  // Byte offset 0 is the most significant lane (mem_we[3], bits [31:24]).
  always_comb begin
    lane_we = 4'b1111;
    repl    = d_wdata;
    case (d_size)
      2'b00: begin
        lane_we = 4'b1000 >> off;
        repl    = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        lane_we = off[1] ? 4'b0011 : 4'b1100;
        repl    = {2{d_wdata[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        repl    = d_wdata;
      end
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (d_gnt) begin
      mem_en   = !misaligned;
      mem_addr = {d_addr[31:2], 2'b00};
      if (d_we && !misaligned) begin
        mem_we    = lane_we;
        mem_wdata = repl;
      end
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = {if_addr[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (d_gnt) begin
        r_off      <= off;
        r_size     <= d_size;
        r_unsigned <= d_unsigned;
        r_we       <= d_we;
        r_err      <= misaligned;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (if_gnt)     state_nxt = RESP_IF;
    else if (d_gnt) state_nxt = RESP_D;
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = mem_rdata[31:24];
    case (r_off)
      2'b00:   ld_byte = mem_rdata[31:24];
      2'b01:   ld_byte = mem_rdata[23:16];
      2'b10:   ld_byte = mem_rdata[15:8];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    if (r_size[1])
      ld_val = mem_rdata;
    else if (r_size[0])
      ld_val = {{16{!r_unsigned && ld_half[15]}}, ld_half};
    else
      ld_val = {{24{!r_unsigned && ld_byte[7]}}, ld_byte};
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    case (state)
      RESP_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_err    = r_err;
        if (!r_we && !r_err) d_rdata = ld_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lane mapping, extension, traps, arbitration, reset.
// Arbitration expectations follow whether MEM_ARB_FAIR_EN is defined for the build.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_if_q[$];

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Tiny synchronous-read memory with fixed contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h0000_0013;
      32'h004: return 32'h0010_0093;
      32'h100: return 32'h1234_F00D;
      32'h200: return 32'h80FF_7F01;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && (mem_we == 4'b0000)) mem_rdata <= mem_word(mem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
    d_addr = addr; d_wdata = wdata;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_if_gnt"}, if_gnt, 0);
    check_eq({tag, "_d_gnt"}, d_gnt, 0);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_if_rvalid"}, if_rvalid, 0);
    check_eq({tag, "_if_rdata"}, if_rdata, 0);
    check_eq({tag, "_d_rvalid"}, d_rvalid, 0);
    check_eq({tag, "_d_rdata"}, d_rdata, 0);
    check_eq({tag, "_d_err"}, d_err, 0);
  endtask

  // One data access: check the issue cycle, then the response cycle.
  task automatic d_access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_en, input logic [3:0] exp_we,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
    @(negedge clk);
    drive_d(we, size, uns, addr, wdata);
    #1;
    check_eq({tag, "_d_gnt"}, d_gnt, 1);
    check_eq({tag, "_if_gnt"}, if_gnt, 0);
    check_eq({tag, "_mem_en"}, mem_en, exp_en);
    check_eq({tag, "_mem_we"}, mem_we, exp_we);
    if (exp_en) begin
      check_eq({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      check_eq({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    end
    @(negedge clk);
    idle();
    #1;
    check_eq({tag, "_d_rvalid"}, d_rvalid, 1);
    check_eq({tag, "_d_err"}, d_err, exp_err);
    check_eq({tag, "_d_rdata"}, d_rdata, exp_rdata);
    check_eq({tag, "_if_rvalid"}, if_rvalid, 0);
  endtask

  typedef struct {
    int          kind;   // 0 idle, 1 fetch, 2 load, 3 load and fetch together
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic pend_if, pend_d;
    logic exp_if_g, exp_d_g;

    // Reset: requests are held active but everything must stay quiet.
    #2 rst_n = 1'b0;
    drive_d(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D);
    drive_if(32'h4);
    @(negedge clk);
    #1 check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Stores: byte/half/word lane enables and replication.
    d_access("st_b102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0);
    d_access("st_b100", 1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055, 1'b1, 4'b1000, 32'h5555_5555, 32'h0, 1'b0);
    d_access("st_h202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_BEEF, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0);
    d_access("st_h200", 1'b1, 2'b01, 1'b0, 32'h200, 32'h0000_1357, 1'b1, 4'b1100, 32'h1357_1357, 32'h0, 1'b0);
    d_access("st_w", 1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);

    // Loads: lane selection and extension.
    d_access("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_F00D, 1'b0);
    d_access("ld_h_u", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000_F00D, 1'b0);
    d_access("ld_h0", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000_1234, 1'b0);
    d_access("ld_b1_s", 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_FFFF, 1'b0);
    d_access("ld_b0_u", 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0);
    d_access("ld_b0_s", 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0);
    d_access("ld_b2_s", 1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0000_007F, 1'b0);
    d_access("ld_w", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h80FF_7F01, 1'b0);
    d_access("ld_w11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h1234_F00D, 1'b0);

    // Misaligned accesses never reach memory and report an error.
    d_access("mis_w203", 1'b0, 2'b10, 1'b0, 32'h203, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    d_access("mis_h101", 1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    d_access("mis_w202", 1'b1, 2'b10, 1'b0, 32'h202, 32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

    // Both requesters held high for six cycles.
    @(negedge clk);
    drive_if(32'h0);
    drive_d(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      #1;
`ifdef MEM_ARB_FAIR_EN
      exp_if_g = (c == 5);
`else
      exp_if_g = 1'b0;
`endif
      exp_d_g = !exp_if_g;
      check_eq($sformatf("arb_c%0d_if_gnt", c), if_gnt, exp_if_g);
      check_eq($sformatf("arb_c%0d_d_gnt", c), d_gnt, exp_d_g);
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    // Mixed stream: one grant per cycle, each response on its own stream.
    vecs[0] = '{1, 32'h000, 2'b10, 1'b0, 32'h0000_0013};
    vecs[1] = '{1, 32'h004, 2'b10, 1'b0, 32'h0010_0093};
    vecs[2] = '{2, 32'h200, 2'b10, 1'b0, 32'h80FF_7F01};
    vecs[3] = '{1, 32'h000, 2'b10, 1'b0, 32'h0000_0013};
    vecs[4] = '{3, 32'h100, 2'b01, 1'b1, 32'h0000_1234};
    vecs[5] = '{1, 32'h004, 2'b10, 1'b0, 32'h0010_0093};
    vecs[6] = '{2, 32'h203, 2'b00, 1'b0, 32'h0000_0001};
    vecs[7] = '{0, 32'h000, 2'b10, 1'b0, 32'h0};
    pend_if = 1'b0;
    pend_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("s%0d_if_rvalid", i), if_rvalid, pend_if);
      check_eq($sformatf("s%0d_d_rvalid", i), d_rvalid, pend_d);
      if (pend_if && exp_if_q.size() > 0)
        check_eq($sformatf("s%0d_if_rdata", i), if_rdata, exp_if_q.pop_front());
      if (pend_d && exp_q.size() > 0)
        check_eq($sformatf("s%0d_d_rdata", i), d_rdata, exp_q.pop_front());
      idle();
      if (vecs[i].kind == 1 || vecs[i].kind == 3) drive_if(vecs[i].kind == 3 ? 32'h4 : vecs[i].addr);
      if (vecs[i].kind >= 2) drive_d(1'b0, vecs[i].size, vecs[i].uns, vecs[i].addr, 32'h0);
      #1;
      pend_if = (vecs[i].kind == 1);
      pend_d  = (vecs[i].kind >= 2);
      check_eq($sformatf("s%0d_if_gnt", i), if_gnt, pend_if);
      check_eq($sformatf("s%0d_d_gnt", i), d_gnt, pend_d);
      if (pend_if) exp_if_q.push_back(vecs[i].exp);
      if (pend_d) exp_q.push_back(vecs[i].exp);
    end
    @(negedge clk);
    check_eq("s_end_if_rvalid", if_rvalid, 0);
    check_eq("s_end_d_rvalid", d_rvalid, 0);
    check_eq("s_q_left", exp_q.size() + exp_if_q.size(), 0);

    // Reset while a fetch response is outstanding discards it.
    @(negedge clk);
    drive_if(32'h4);
    #1 check_eq("rr_if_gnt", if_gnt, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive_d(1'b1, 2'b00, 1'b0, 32'h101, 32'h77);
    @(negedge clk);
    #1 check_all_zero("rr");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    #1;
    check_eq("rr_post_if_rvalid", if_rvalid, 0);
    check_eq("rr_post_d_rvalid", d_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous-read memory port between the instruction-fetch stage and the load/store stage of the Hunter_RV32 core. Each cycle it grants at most one requester and drives the memory address, byte-lane write enables and replicated write data. It routes the read data back one cycle later, extracting and extending bytes and halfwords for loads. Misaligned data accesses are trapped here and never reach memory.

## Interface
- STARVE_MAX, 4: maximum consecutive cycles a pending fetch may be refused (used only with MEM_ARB_FAIR_EN); range 1–15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address, word-aligned.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetch word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- d_unsigned  in  1  zero-extend loads (lbu/lhu).
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response (loads and stores).
- d_rdata  out  32  extended load result; 0 for stores and errors.
- d_err  out  1  misaligned access, qualified by d_rvalid.
- mem_en  out  1  memory access this cycle.
- mem_we  out  4  byte write enables.
- mem_addr  out  32  d_addr/if_addr with [1:0] forced to 00.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0.

## Operation
- Lane order: byte offset 0 maps to mem_we[3] and bits [31:24]; offset 3 maps to mem_we[0] and bits [7:0].
- Write enables:
  - Byte: 4'b1000 >> offset.
  - Half: offset 00 gives 1100; offset 10 gives 0011.
  - Word: 1111.
  - Loads: 0000.
- Write data replication:
  - Byte: {4{d_wdata[7:0]}}.
  - Half: {2{d_wdata[15:0]}}.
  - Word: d_wdata unchanged.
- Misaligned accesses are a half at offset x1 or a word at any offset other than 00.
  - d_gnt = 1 and mem_en = 0.
  - Next cycle: d_rvalid = 1, d_err = 1, d_rdata = 0.
- Arbitration:
  - Data has priority. If d_req is high, d_gnt = 1; otherwise, if if_req is high, if_gnt = 1.
  - if_gnt and d_gnt are never both high.
- Response FSM: states IDLE, RESP_IF, RESP_D.
  - The next state is set by the grant issued this cycle: IF grant goes to RESP_IF, data grant goes to RESP_D, no grant goes to IDLE.
  - Back-to-back grants are allowed: one access per cycle.
  - The FSM registers offset, size, d_unsigned, d_we and the error flag for RESP_D.
- Responses:
  - RESP_IF: if_rvalid = 1 and if_rdata = mem_rdata.
  - RESP_D:
    - A load returns the selected lane, sign- or zero-extended.
    - A store returns d_rvalid with d_rdata = 0.
- Requesters must accept every response; there is no response backpressure.

## Timing
- Grants, mem_en, mem_we, mem_addr and mem_wdata are combinational from requests in the issue cycle.
- Responses arrive one cycle after the grant.
- d_rdata, d_rvalid, d_err and if_rvalid are combinational from the FSM state, registered fields and mem_rdata.
- Reset values:
  - FSM = IDLE, starvation counter = 0.
  - All valid, grant, error and write-enable outputs = 0.
  - All data outputs = 0.
- While rst_n is low, all grants and mem_en are forced to 0.
- Reset asserted with a response outstanding discards that response; no rvalid follows reset release.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit counter increments each cycle that if_req = 1 and if_gnt = 0, and clears on if_gnt.
  - When the counter equals STARVE_MAX, fetch wins over a pending d_req for one cycle.
- MEM_ARB_FAIR_EN undefined:
  - No counter is built; strict data priority applies.
  - Fetch can starve indefinitely.

## Test plan
- Store byte: d_size = 00, d_addr = 0x102, d_wdata = 0xAB → mem_we = 0010, mem_wdata = 0xABABABAB, mem_addr = 0x100; d_rvalid next cycle.
- Load half signed: mem_rdata = 0x1234F00D, d_addr offset 10 → d_rdata = 0xFFFFF00D; with d_unsigned = 1 → 0x0000F00D.
- Misaligned word load at 0x203 → mem_en = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
- if_req and d_req both held high for 6 cycles, STARVE_MAX = 4, MEM_ARB_FAIR_EN defined → d_gnt for 4 cycles, if_gnt on cycle 5. Without the macro → d_gnt on all 6 cycles.
- Alternating fetch at 0x0 and 0x4 with a load in the same stream → one grant per cycle, each response in the correct stream one cycle later, no lost or duplicated rvalid.
- rst_n pulsed low on the cycle after an IF grant → no if_rvalid; all outputs are 0 during reset.
